// File: rtl/buffer_readout.sv
// Event readout from the circular sample buffer: reads N_SAMPLES consecutive addresses
// starting PRE_SAMPLES before the L0 address and streams them out through a 2-entry FIFO.
module buffer_readout #(
  parameter int PRE_SAMPLES = 8,
  parameter int N_SAMPLES   = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  address_L0,
  output logic [7:0]  rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic [11:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        readout_end
);

  localparam logic [7:0] PRE_OFS = 8'(PRE_SAMPLES);
  localparam logic [8:0] N_LOAD  = 9'(N_SAMPLES);

  typedef enum logic [2:0] {IDLE, SETUP, READ, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [7:0]        base;
  logic [8:0]        remaining;
  logic [1:0]        occ;
  logic              infl;
  logic [1:0][11:0]  fifo_mem;
  logic              wr_ptr, rd_ptr;
  logic              push, pop;
  logic [2:0]        committed;

  assign push        = infl;
  assign pop         = dout_valid & dout_ready;
  assign dout_valid  = (occ != 2'd0);
  assign dout        = fifo_mem[rd_ptr];
  assign busy        = (state != IDLE);
  assign readout_end = (state == DONE);

  // Slots already spoken for next cycle; a read is only issued if one stays free,
  // so the FIFO can never overflow when the in-flight datum lands.
  assign committed = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SETUP;
      SETUP: state_nxt = READ;
      READ: begin
        if (remaining != 9'd0 && committed < 3'd2) rd_en = 1'b1;
        if (remaining == 9'd0 || (rd_en && remaining == 9'd1)) state_nxt = DRAIN;
      end
      DRAIN: if (occ == 2'd0 && !infl) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      base      <= '0;
      remaining <= '0;
      rd_addr   <= '0;
      infl      <= 1'b0;
      occ       <= '0;
      fifo_mem  <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      state <= state_nxt;
      infl  <= rd_en;
      if (state == IDLE && start) begin
        base      <= address_L0 - PRE_OFS;
        remaining <= N_LOAD;
      end
      if (state == SETUP) rd_addr <= base;
      if (rd_en) begin
        rd_addr   <= rd_addr + 8'd1;
        remaining <= remaining - 9'd1;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_buffer_readout.sv
// Directed bench for buffer_readout: a behavioural 1-cycle-latency buffer feeds two
// instances (N=128 and N=16); each event is scored against the expected address/data sequence.
module tb_buffer_readout;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  address_L0 = '0;
  logic        dout_ready = 1'b1;

  logic [7:0]  a_rd_addr, b_rd_addr;
  logic        a_rd_en, b_rd_en;
  logic [11:0] a_rd_data = '0, b_rd_data = '0;
  logic [11:0] a_dout, b_dout;
  logic        a_dv, b_dv, a_busy, b_busy, a_end, b_end;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  buffer_readout u_a (
    .clk(clk), .reset(reset), .start(start_a), .address_L0(address_L0),
    .rd_addr(a_rd_addr), .rd_en(a_rd_en), .rd_data(a_rd_data),
    .dout(a_dout), .dout_valid(a_dv), .dout_ready(dout_ready),
    .busy(a_busy), .readout_end(a_end));

  buffer_readout #(.PRE_SAMPLES(8), .N_SAMPLES(16)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .address_L0(address_L0),
    .rd_addr(b_rd_addr), .rd_en(b_rd_en), .rd_data(b_rd_data),
    .dout(b_dout), .dout_valid(b_dv), .dout_ready(dout_ready),
    .busy(b_busy), .readout_end(b_end));

  function automatic logic [11:0] memf(input logic [7:0] a);
    return {a[3:0] ^ 4'h5, a};
  endfunction

  // sample buffer: data for the address read appears one cycle after rd_en
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= memf(a_rd_addr);
    if (b_rd_en) b_rd_data <= memf(b_rd_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode: 0 ready=1, 1 random ready, 2 stall 20 cycles, 3 second start + addr churn, 4 reset at sample 50
  task automatic run_ev(input bit sel, input logic [7:0] addr, input int mode, input int n, input bit armed);
    logic [7:0]  base, ak, s_addr;
    logic [7:0]  aq[$];
    logic [11:0] dq[$];
    logic [11:0] held, s_dout;
    bit          held_v, done, s_en, s_dv, s_end, s_busy;
    int          c, fv, tfirst, tlast, cend, rend, maxout, reads20, stab_err, addr_err, data_err;
    base = addr - 8'd8;
    held = '0; held_v = 0; done = 0;
    c = 0; fv = 0; tfirst = 0; tlast = 0; cend = 0; rend = 0; maxout = 0;
    reads20 = 0; stab_err = 0; addr_err = 0; data_err = 0;
    if (!armed) begin
      @(posedge clk); #1;
      address_L0 = addr;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
    end
    while (!done && c < 2000) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) begin start_a = 1'b0; start_b = 1'b0; end
      case (mode)
        1: dout_ready = ($urandom_range(0, 1) == 1);
        2: dout_ready = (c > 20);
        3: begin
          dout_ready = 1'b1;
          address_L0 = 8'(c * 3);
          if (c == 10) begin if (sel) start_b = 1'b1; else start_a = 1'b1; end
          if (c == 11) begin start_a = 1'b0; start_b = 1'b0; end
        end
        default: dout_ready = 1'b1;
      endcase
      @(negedge clk); #1;
      s_en   = sel ? b_rd_en : a_rd_en;
      s_addr = sel ? b_rd_addr : a_rd_addr;
      s_dv   = sel ? b_dv : a_dv;
      s_dout = sel ? b_dout : a_dout;
      s_end  = sel ? b_end : a_end;
      s_busy = sel ? b_busy : a_busy;
      if (c == 1) chk("busy_after_start", 32'(s_busy), 1);
      if (s_en) aq.push_back(s_addr);
      if (s_dv && fv == 0) fv = c;
      if (s_dv && dout_ready) begin
        if (dq.size() == 0) tfirst = c;
        tlast = c;
        dq.push_back(s_dout);
      end
      if (s_dv && !dout_ready) begin
        if (held_v && s_dout !== held) stab_err++;
        held = s_dout; held_v = 1;
      end else held_v = 0;
      if (aq.size() - dq.size() > maxout) maxout = aq.size() - dq.size();
      if (mode == 2 && c == 20) reads20 = aq.size();
      if (s_end) begin
        rend++;
        if (cend == 0) begin
          cend = c;
          chk("busy_at_end", 32'(s_busy), 1);
        end
      end
      if (cend != 0 && c == cend + 1) chk("busy_after_end", 32'(s_busy), 0);
      if (cend != 0 && c >= cend + 3) done = 1;
      if (mode == 4 && dq.size() == 50) begin
        reset = 1'b0; #1;
        chk("rst_rd_addr", 32'(a_rd_addr), 0);
        chk("rst_rd_en", 32'(a_rd_en), 0);
        chk("rst_dout", 32'(a_dout), 0);
        chk("rst_dout_valid", 32'(a_dv), 0);
        chk("rst_busy", 32'(a_busy), 0);
        done = 1;
      end
    end
    if (mode == 4) begin
      chk("rst_no_end", rend, 0);
      return;
    end
    chk("end_seen_in_budget", 32'(cend != 0), 1);
    chk("xfers", dq.size(), n);
    chk("reads", aq.size(), n);
    chk("rend_count", rend, 1);
    for (int k = 0; k < n; k++) begin
      ak = base + 8'(k);
      if (k < aq.size() && aq[k] !== ak) addr_err++;
      if (k < dq.size() && dq[k] !== memf(ak)) data_err++;
    end
    chk("addr_seq", addr_err, 0);
    chk("data_order", data_err, 0);
    if (aq.size() > 0) begin
      chk("first_addr", 32'(aq[0]), 32'(base));
      chk("last_addr", 32'(aq[aq.size()-1]), 32'(8'(base + 8'(n - 1))));
    end
    chk("outstanding_le2", 32'(maxout <= 2), 1);
    if (mode == 0) begin
      chk("first_valid_latency", fv - 1, 3);
      chk("throughput_span", tlast - tfirst, n - 1);
    end
    if (mode == 2) begin
      chk("reads_while_stalled", 32'(reads20 <= 2), 1);
      chk("stall_dout_stable", stab_err, 0);
    end
  endtask

  initial begin
    #22;
    chk("reset_rd_addr", 32'(a_rd_addr), 0);
    chk("reset_rd_en", 32'(a_rd_en), 0);
    chk("reset_dout", 32'(a_dout), 0);
    chk("reset_dout_valid", 32'(a_dv), 0);
    chk("reset_busy", 32'(a_busy), 0);
    chk("reset_readout_end", 32'(a_end), 0);
    @(negedge clk); reset = 1'b1;

    run_ev(0, 8'h40, 0, 128, 0);   // base 0x38, 0x38..0xB7
    run_ev(1, 8'h03, 0, 16, 0);    // base 0xFB, wraps to 0x0A
    run_ev(0, 8'h10, 1, 128, 0);
    run_ev(0, 8'h02, 2, 128, 0);   // base 0xFA, wrap under stall
    run_ev(0, 8'h40, 3, 128, 0);
    run_ev(0, 8'h40, 4, 128, 0);

    repeat (3) @(negedge clk);
    chk("reset_hold_end", 32'(a_end), 0);
    start_a = 1'b1;
    address_L0 = 8'h80;
    #1 reset = 1'b1;
    run_ev(0, 8'h80, 0, 128, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
